status_flags: RTL and testbench
===============================

Name: status_flags

Overview:
- Processor status (P) register stage directly downstream of the 6502 ALU.
- Captures the ALU's C/Z/V/N outputs under per-flag masks. Also handles flag loads from the data bus (PLP/RTI/BIT) and SEx/CLx set/clear operations.
- Feeds the carry and decimal mode back to the ALU.
- Evaluates branch conditions, and synchronises/latches IRQ and NMI for the sequencer.

Parameters:
- RESET_P, 8'h24, P value after reset (I=1, bit5=1, rest 0).
- BCD_EN, 1, when 0 the D flag is forced to 0 and can never be set (2A03-style core).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- p_op  in  3  operation: 0 HOLD, 1 ALU, 2 LOAD, 3 SET, 4 CLR, 5 BIT, 6 INT_ENTRY, 7 HOLD
- p_mask  in  8  per-bit flag select (bit0 C, 1 Z, 2 I, 3 D, 6 V, 7 N) for ALU/SET/CLR
- alu_c, alu_z, alu_v, alu_n  in  1 each  ALU flag outputs, same cycle
- db_in  in  8  data bus byte for LOAD/BIT
- irq_n  in  1  asynchronous level IRQ, active-low
- nmi_n  in  1  asynchronous NMI, falling-edge triggered
- int_ack  in  1  sequencer accepting an interrupt this cycle
- push_brk  in  1  B value to place in p_push
- cc_sel  in  3  branch opcode bits [7:5]
- p_out  out  8  live P: {N,V,1,1,D,I,Z,C}
- p_push  out  8  P for stacking: {N,V,1,push_brk,D,I,Z,C}
- carry_out  out  1  C, to ALU c_in
- dec_mode  out  1  D, to ALU
- branch_taken  out  1  combinational branch decision
- irq_pending  out  1  registered
- nmi_pending  out  1  registered

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - Flags = RESET_P (D forced 0 if BCD_EN=0).
  - Sync flops = 1.
  - nmi latch = 0, irq_pending = 0, nmi_pending = 0.
  - I_delayed = 1.
  - Reset asserted mid-operation overrides everything immediately.
- Flag storage:
  - Six flops C, Z, I, D, V, N.
  - Bits 5 and 4 are not stored: bit5 always reads 1, and bit4 reads 1 in p_out and push_brk in p_push.
- p_op semantics (take effect at the clock edge; all outputs derived from flags update the cycle after):
  - ALU: for each of C/Z/V/N whose mask bit is 1, the flag takes the ALU value. I and D are unaffected regardless of mask.
  - LOAD: C, Z, I, D, V, N take db_in bits 0, 1, 2, 3, 6, 7. db_in[5:4] is ignored.
  - SET: every flag with mask=1 is set. CLR: every flag with mask=1 is cleared.
  - BIT: N=db_in[7], V=db_in[6], Z=alu_z (ALU performing AND). C, I, D are unchanged.
  - INT_ENTRY: I=1; other flags unchanged.
  - HOLD/7: no change.
- BCD_EN=0: any write of 1 to D is discarded; dec_mode is constant 0.
- Branch condition:
  - cc_sel[2:1] selects the flag: 00 N, 01 V, 10 C, 11 Z.
  - branch_taken = (selected flag == cc_sel[0]), using the current registered flags.
- IRQ path:
  - irq_n passes through a 2-flop synchroniser.
  - I_delayed is the I flag registered one cycle, so CLI/SEI/PLP take effect on interrupt polling one cycle late.
  - irq_pending(next) = ~irq_sync & ~I_delayed.
  - Level-sensitive: int_ack does not clear it; removing irq_n or setting I does.
- NMI path:
  - nmi_n passes through a 2-flop synchroniser plus one edge flop.
  - A synced 1->0 transition sets the nmi latch. nmi_pending = nmi latch.
  - int_ack while nmi_pending=1 clears the latch. int_ack while nmi_pending=0 leaves it unchanged.
  - A new edge detected in the same cycle as a clearing ack leaves the latch set (edge wins).
  - A held-low nmi_n produces only one latch event.
- Latency:
  - irq_n edge to irq_pending: 3 cycles.
  - nmi_n fall to nmi_pending: 4 cycles (2 sync + edge + latch).

Decomposition:
- Shared package/include (alongside the ALU op definitions):
  - p_op encodings.
  - Flag bit-index constants (FLAG_C=0 … FLAG_N=7).
  - RESET_P default.
- Sub-module: sync2 (2-flop synchroniser, async active-low reset to 1), instantiated for irq_n and nmi_n.

Test Plan:
1. Reset: rst_n low mid-run with flags 8'hFF -> p_out=8'h34 asynchronously; irq_pending=0, nmi_pending=0.
2. ALU mask: p_mask=8'h83, alu_c=1, alu_z=0, alu_n=1, alu_v=1, p_op=ALU -> C=1, Z=0, N=1, V unchanged; carry_out=1 the next cycle.
3. LOAD/push: db_in=8'hCB, LOAD -> p_out=8'hFB; push_brk=0 -> p_push=8'hEB. With BCD_EN=0 -> p_out=8'hF3.
4. Branch: Z=1, cc_sel=3'b111 -> branch_taken=1; cc_sel=3'b110 -> 0; C=0, cc_sel=3'b100 -> 1.
5. IRQ/CLI: irq_n low with I=1 -> irq_pending stays 0. CLR mask 8'h04 -> irq_pending=1 exactly 2 cycles after the CLR edge; int_ack does not clear it.
6. NMI: nmi_n falls and is held low -> nmi_pending=1 after 4 cycles. int_ack -> 0 and stays 0 while nmi_n is held low. A second fall coinciding with the ack cycle -> stays 1.

Source files
------------

// File: rtl/status_flags_pkg.sv
// Shared definitions for the 6502 processor status stage: P-op encodings,
// flag bit positions and the default post-reset P value.
package status_flags_pkg;

  localparam int P_OP_W = 3;

  typedef enum logic [P_OP_W-1:0] {
    P_HOLD      = 3'd0,
    P_ALU       = 3'd1,
    P_LOAD      = 3'd2,
    P_SET       = 3'd3,
    P_CLR       = 3'd4,
    P_BIT       = 3'd5,
    P_INT_ENTRY = 3'd6,
    P_HOLD7     = 3'd7
  } p_op_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_B = 4;
  localparam int FLAG_U = 5;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  localparam logic [7:0] RESET_P_DEFAULT = 8'h24;

  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } flags_t;

  // Bit 5 is hard-wired to 1; bit 4 is only a stacking artefact (B), never stored.
  function automatic logic [7:0] pack_p(flags_t f, logic b);
    return {f.n, f.v, 1'b1, b, f.d, f.i, f.z, f.c};
  endfunction

endpackage

// File: rtl/status_flags_if.sv
// Sequencer/ALU-facing bundle of the status stage: flag operations in,
// live/stacked P, branch decision and interrupt requests out.
interface status_flags_if;
  import status_flags_pkg::*;

  logic [P_OP_W-1:0] p_op;
  logic [7:0]        p_mask;
  logic              alu_c;
  logic              alu_z;
  logic              alu_v;
  logic              alu_n;
  logic [7:0]        db_in;
  logic              irq_n;
  logic              nmi_n;
  logic              int_ack;
  logic              push_brk;
  logic [2:0]        cc_sel;
  logic [7:0]        p_out;
  logic [7:0]        p_push;
  logic              carry_out;
  logic              dec_mode;
  logic              branch_taken;
  logic              irq_pending;
  logic              nmi_pending;

  modport master (
    output p_op, p_mask, alu_c, alu_z, alu_v, alu_n, db_in,
           irq_n, nmi_n, int_ack, push_brk, cc_sel,
    input  p_out, p_push, carry_out, dec_mode, branch_taken,
           irq_pending, nmi_pending
  );

  modport slave (
    input  p_op, p_mask, alu_c, alu_z, alu_v, alu_n, db_in,
           irq_n, nmi_n, int_ack, push_brk, cc_sel,
    output p_out, p_push, carry_out, dec_mode, branch_taken,
           irq_pending, nmi_pending
  );

endinterface

// File: rtl/status_flags_sync2.sv
// Two-flop synchroniser for the active-low interrupt pins; resets to the
// inactive (high) level so no spurious request is seen leaving reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= 2'b11;
    end else begin
      stage_q <= {stage_q[0], d_i};
    end
  end

  assign q_o = stage_q[1];

endmodule

// File: rtl/status_flags.sv
// 6502 P register stage: flag updates from ALU/bus/SEx/CLx, branch
// condition evaluation and IRQ/NMI synchronisation for the sequencer.
module status_flags
  import status_flags_pkg::*;
#(
  parameter logic [7:0] RESET_P = RESET_P_DEFAULT,
  parameter bit         BCD_EN  = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  status_flags_if.slave bus
);

  localparam flags_t FLAGS_RST = '{
    n: RESET_P[FLAG_N],
    v: RESET_P[FLAG_V],
    d: RESET_P[FLAG_D] & BCD_EN,
    i: RESET_P[FLAG_I],
    z: RESET_P[FLAG_Z],
    c: RESET_P[FLAG_C]
  };

  p_op_e  op;
  flags_t flags_q, flags_d;
  logic   sel_flag;
  logic   irq_sync, nmi_sync;
  logic   i_dly_q, irq_pending_q;
  logic   nmi_prev_q, nmi_edge_q, nmi_latch_q;
  logic   unused_bits;

  assign op          = p_op_e'(bus.p_op);
  assign unused_bits = ^{bus.p_mask[FLAG_U:FLAG_B], bus.db_in[FLAG_U:FLAG_B]};

  always_comb begin
    flags_d = flags_q;
    case (op)
      P_ALU: begin
        if (bus.p_mask[FLAG_C]) flags_d.c = bus.alu_c;
        if (bus.p_mask[FLAG_Z]) flags_d.z = bus.alu_z;
        if (bus.p_mask[FLAG_V]) flags_d.v = bus.alu_v;
        if (bus.p_mask[FLAG_N]) flags_d.n = bus.alu_n;
      end
      P_LOAD: begin
        flags_d.c = bus.db_in[FLAG_C];
        flags_d.z = bus.db_in[FLAG_Z];
        flags_d.i = bus.db_in[FLAG_I];
        flags_d.d = bus.db_in[FLAG_D];
        flags_d.v = bus.db_in[FLAG_V];
        flags_d.n = bus.db_in[FLAG_N];
      end
      P_SET: begin
        flags_d.c = flags_q.c | bus.p_mask[FLAG_C];
        flags_d.z = flags_q.z | bus.p_mask[FLAG_Z];
        flags_d.i = flags_q.i | bus.p_mask[FLAG_I];
        flags_d.d = flags_q.d | bus.p_mask[FLAG_D];
        flags_d.v = flags_q.v | bus.p_mask[FLAG_V];
        flags_d.n = flags_q.n | bus.p_mask[FLAG_N];
      end
      P_CLR: begin
        flags_d.c = flags_q.c & ~bus.p_mask[FLAG_C];
        flags_d.z = flags_q.z & ~bus.p_mask[FLAG_Z];
        flags_d.i = flags_q.i & ~bus.p_mask[FLAG_I];
        flags_d.d = flags_q.d & ~bus.p_mask[FLAG_D];
        flags_d.v = flags_q.v & ~bus.p_mask[FLAG_V];
        flags_d.n = flags_q.n & ~bus.p_mask[FLAG_N];
      end
      // BIT: Z comes from the ALU's AND result, N/V straight from memory.
      P_BIT: begin
        flags_d.n = bus.db_in[FLAG_N];
        flags_d.v = bus.db_in[FLAG_V];
        flags_d.z = bus.alu_z;
      end
      P_INT_ENTRY: flags_d.i = 1'b1;
      default: ;
    endcase
    if (!BCD_EN) flags_d.d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= FLAGS_RST;
    end else begin
      flags_q <= flags_d;
    end
  end

  always_comb begin
    sel_flag = 1'b0;
    case (bus.cc_sel[2:1])
      2'b00:   sel_flag = flags_q.n;
      2'b01:   sel_flag = flags_q.v;
      2'b10:   sel_flag = flags_q.c;
      default: sel_flag = flags_q.z;
    endcase
  end

  assign bus.branch_taken = (sel_flag == bus.cc_sel[0]);
  assign bus.p_out        = pack_p(flags_q, 1'b1);
  assign bus.p_push       = pack_p(flags_q, bus.push_brk);
  assign bus.carry_out    = flags_q.c;
  assign bus.dec_mode     = BCD_EN ? flags_q.d : 1'b0;

  sync2 u_irq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.irq_n),
    .q_o   (irq_sync)
  );

  sync2 u_nmi_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.nmi_n),
    .q_o   (nmi_sync)
  );

  // I is polled through a one-cycle delay so CLI/SEI/PLP act one cycle late;
  // an NMI edge arriving with a clearing ack keeps the latch set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_dly_q       <= 1'b1;
      irq_pending_q <= 1'b0;
      nmi_prev_q    <= 1'b1;
      nmi_edge_q    <= 1'b0;
      nmi_latch_q   <= 1'b0;
    end else begin
      i_dly_q       <= flags_q.i;
      irq_pending_q <= ~irq_sync & ~i_dly_q;
      nmi_prev_q    <= nmi_sync;
      nmi_edge_q    <= nmi_prev_q & ~nmi_sync;
      if (nmi_edge_q) begin
        nmi_latch_q <= 1'b1;
      end else if (bus.int_ack && nmi_latch_q) begin
        nmi_latch_q <= 1'b0;
      end
    end
  end

  assign bus.irq_pending = irq_pending_q;
  assign bus.nmi_pending = nmi_latch_q;

endmodule

// File: tb/tb_status_flags.sv
// Directed bench for status_flags: one BCD and one 2A03-style instance share
// stimulus and are compared every cycle against a history-based model.
module tb_status_flags;
  import status_flags_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] pOp = 3'd0;
  logic [7:0] pMask = 8'h00;
  logic [7:0] dbIn = 8'h00;
  logic       aluC = 1'b0, aluZ = 1'b0, aluV = 1'b0, aluN = 1'b0;
  logic       irqN = 1'b1, nmiN = 1'b1, intAck = 1'b0, pushBrk = 1'b0;
  logic [2:0] ccSel = 3'd0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  status_flags_if busA ();
  status_flags_if busB ();

  assign busA.p_op = pOp;      assign busB.p_op = pOp;
  assign busA.p_mask = pMask;  assign busB.p_mask = pMask;
  assign busA.alu_c = aluC;    assign busB.alu_c = aluC;
  assign busA.alu_z = aluZ;    assign busB.alu_z = aluZ;
  assign busA.alu_v = aluV;    assign busB.alu_v = aluV;
  assign busA.alu_n = aluN;    assign busB.alu_n = aluN;
  assign busA.db_in = dbIn;    assign busB.db_in = dbIn;
  assign busA.irq_n = irqN;    assign busB.irq_n = irqN;
  assign busA.nmi_n = nmiN;    assign busB.nmi_n = nmiN;
  assign busA.int_ack = intAck;   assign busB.int_ack = intAck;
  assign busA.push_brk = pushBrk; assign busB.push_brk = pushBrk;
  assign busA.cc_sel = ccSel;  assign busB.cc_sel = ccSel;

  status_flags #(.RESET_P(8'h24), .BCD_EN(1'b1)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA.slave)
  );

  status_flags #(.RESET_P(8'h24), .BCD_EN(1'b0)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB.slave)
  );

  // Model keeps flags as a byte with bits 5:4 zero; interrupt paths are
  // expressed as "what the pins/I flag were N edges ago".
  logic [7:0] mFlagsA = 8'h04, mFlagsB = 8'h04, nextA, nextB;
  logic [1:0] irqHist = 2'b11;
  logic [3:0] nmiHist = 4'hF;
  logic [1:0] iHist = 2'b11;
  logic       mIrqPend = 1'b0, mNmiLatch = 1'b0;

  function automatic logic [7:0] nextFlags(logic [7:0] f, logic bcd, logic [2:0] op,
                                           logic [7:0] mask, logic [7:0] db,
                                           logic c, logic z, logic v, logic n);
    logic [7:0] r, m;
    r = f;
    m = mask & 8'hC3;
    case (op)
      3'd1: r = (f & ~m) | ({n, v, 4'b0000, z, c} & m);
      3'd2: r = db & 8'hCF;
      3'd3: r = f | (mask & 8'hCF);
      3'd4: r = f & ~(mask & 8'hCF);
      3'd5: r = {db[7:6], f[5:2], z, f[0]};
      3'd6: r = f | 8'h04;
      default: r = f;
    endcase
    if (!bcd) r[3] = 1'b0;
    return r;
  endfunction

  function automatic logic expBranch(logic [7:0] f, logic [2:0] cc);
    logic [3:0] pick;
    pick = {f[1], f[0], f[6], f[7]};
    return pick[cc[2:1]] == cc[0];
  endfunction

  always_comb begin
    nextA = nextFlags(mFlagsA, 1'b1, pOp, pMask, dbIn, aluC, aluZ, aluV, aluN);
    nextB = nextFlags(mFlagsB, 1'b0, pOp, pMask, dbIn, aluC, aluZ, aluV, aluN);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mFlagsA <= 8'h04; mFlagsB <= 8'h04;
      irqHist <= 2'b11; nmiHist <= 4'hF; iHist <= 2'b11;
      mIrqPend <= 1'b0; mNmiLatch <= 1'b0;
    end else begin
      mFlagsA   <= nextA;
      mFlagsB   <= nextB;
      mIrqPend  <= ~irqHist[1] & ~iHist[1];
      mNmiLatch <= (nmiHist[3] & ~nmiHist[2]) ? 1'b1 : (intAck ? 1'b0 : mNmiLatch);
      irqHist   <= {irqHist[0], irqN};
      nmiHist   <= {nmiHist[2:0], nmiN};
      iHist     <= {iHist[0], nextA[2]};
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("A.p_out", busA.p_out, mFlagsA | 8'h30);
    checkOutput("A.p_push", busA.p_push, mFlagsA | 8'h20 | {3'b000, pushBrk, 4'h0});
    checkOutput("A.carry", {7'd0, busA.carry_out}, {7'd0, mFlagsA[0]});
    checkOutput("A.dec", {7'd0, busA.dec_mode}, {7'd0, mFlagsA[3]});
    checkOutput("A.branch", {7'd0, busA.branch_taken}, {7'd0, expBranch(mFlagsA, ccSel)});
    checkOutput("A.irq", {7'd0, busA.irq_pending}, {7'd0, mIrqPend});
    checkOutput("A.nmi", {7'd0, busA.nmi_pending}, {7'd0, mNmiLatch});
    checkOutput("B.p_out", busB.p_out, mFlagsB | 8'h30);
    checkOutput("B.dec", {7'd0, busB.dec_mode}, 8'h00);
    checkOutput("B.branch", {7'd0, busB.branch_taken}, {7'd0, expBranch(mFlagsB, ccSel)});
    checkOutput("B.irq", {7'd0, busB.irq_pending}, {7'd0, mIrqPend});
    checkOutput("B.nmi", {7'd0, busB.nmi_pending}, {7'd0, mNmiLatch});
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] mask, input logic [7:0] db);
    pOp = op; pMask = mask; dbIn = db;
    idle(1);
    pOp = 3'd0;
  endtask

  initial begin
    #23 rst_n = 1'b1;
    idle(2);
    checkOutput("rst_pout", busA.p_out, 8'h34);
    checkOutput("rst_irq", {7'd0, busA.irq_pending}, 8'h00);
    checkOutput("rst_nmi", {7'd0, busA.nmi_pending}, 8'h00);

    aluC = 1'b1; aluZ = 1'b0; aluN = 1'b1; aluV = 1'b1;
    applyStimulus(3'd1, 8'h83, 8'h00);
    checkOutput("alu_pout", busA.p_out, 8'hB5);
    checkOutput("alu_carry", {7'd0, busA.carry_out}, 8'h01);

    applyStimulus(3'd2, 8'h00, 8'hCB);
    checkOutput("load_poutA", busA.p_out, 8'hFB);
    checkOutput("load_poutB", busB.p_out, 8'hF3);
    checkOutput("load_push0", busA.p_push, 8'hEB);
    pushBrk = 1'b1; #1;
    checkOutput("load_push1", busA.p_push, 8'hFB);
    pushBrk = 1'b0;

    ccSel = 3'b111; #1;
    checkOutput("br_z1", {7'd0, busA.branch_taken}, 8'h01);
    ccSel = 3'b110; #1;
    checkOutput("br_z0", {7'd0, busA.branch_taken}, 8'h00);
    applyStimulus(3'd4, 8'h01, 8'h00);
    ccSel = 3'b100; #1;
    checkOutput("br_c0", {7'd0, busA.branch_taken}, 8'h01);

    aluZ = 1'b1;
    applyStimulus(3'd5, 8'h00, 8'h40);
    checkOutput("bit_pout", busA.p_out, 8'h7A);

    for (int k = 0; k < 8; k++) begin
      ccSel = 3'(k);
      {aluN, aluV, aluZ, aluC} = 4'(k * 5);
      case (k % 4)
        0: applyStimulus(3'd3, 8'h41, 8'h00);
        1: applyStimulus(3'd4, 8'hC2, 8'h00);
        2: applyStimulus(3'd1, 8'hFF, 8'h00);
        default: applyStimulus(3'(5 + (k / 4)), 8'h08, 8'hB7);
      endcase
      applyStimulus(3'((k / 2) + 3), 8'h08, 8'h00);
    end

    applyStimulus(3'd3, 8'h04, 8'h00);
    irqN = 1'b0;
    idle(5);
    checkOutput("irq_masked", {7'd0, busA.irq_pending}, 8'h00);
    applyStimulus(3'd4, 8'h04, 8'h00);
    checkOutput("cli_e1", {7'd0, busA.irq_pending}, 8'h00);
    idle(1);
    checkOutput("cli_e2_still0", {7'd0, busA.irq_pending}, 8'h00);
    idle(1);
    checkOutput("cli_irq", {7'd0, busA.irq_pending}, 8'h01);
    intAck = 1'b1;
    idle(3);
    checkOutput("irq_ack_level", {7'd0, busA.irq_pending}, 8'h01);
    intAck = 1'b0;
    applyStimulus(3'd6, 8'h00, 8'h00);
    idle(3);
    checkOutput("irq_int_entry", {7'd0, busA.irq_pending}, 8'h00);
    applyStimulus(3'd4, 8'h04, 8'h00);
    idle(3);
    irqN = 1'b1;
    idle(4);
    checkOutput("irq_release", {7'd0, busA.irq_pending}, 8'h00);

    nmiN = 1'b0;
    idle(3);
    checkOutput("nmi_e3", {7'd0, busA.nmi_pending}, 8'h00);
    idle(1);
    checkOutput("nmi_e4", {7'd0, busA.nmi_pending}, 8'h01);
    intAck = 1'b1;
    idle(1);
    intAck = 1'b0;
    checkOutput("nmi_ack", {7'd0, busA.nmi_pending}, 8'h00);
    idle(5);
    checkOutput("nmi_held", {7'd0, busA.nmi_pending}, 8'h00);
    nmiN = 1'b1;
    idle(5);
    nmiN = 1'b0;
    idle(4);
    checkOutput("nmi_second", {7'd0, busA.nmi_pending}, 8'h01);
    nmiN = 1'b1;
    idle(6);
    nmiN = 1'b0;
    idle(3);
    intAck = 1'b1;
    idle(1);
    intAck = 1'b0;
    checkOutput("nmi_edge_wins", {7'd0, busA.nmi_pending}, 8'h01);
    idle(1);
    checkOutput("nmi_kept", {7'd0, busA.nmi_pending}, 8'h01);

    applyStimulus(3'd3, 8'hFF, 8'h00);
    checkOutput("set_ffA", busA.p_out, 8'hFF);
    checkOutput("set_ffB", busB.p_out, 8'hF7);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_pout", busA.p_out, 8'h34);
    checkOutput("midrst_irq", {7'd0, busA.irq_pending}, 8'h00);
    checkOutput("midrst_nmi", {7'd0, busA.nmi_pending}, 8'h00);
    idle(1);
    #2 rst_n = 1'b1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
